// File: rtl/sevenseg_scanner.sv
// rtl/sevenseg_scanner.sv - multiplexed 8-digit common-anode 7-segment driver
// Loads are double-buffered and committed at the 7->0 digit wrap so a frame never tears.
module sevenseg_scanner #(
  parameter int CLK_FREQ_HZ  = 12_500_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_value,
  input  logic [7:0]  i_en,
  input  logic [7:0]  i_dp,
  input  logic        i_load,
  output logic [7:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp_n,
  output logic        o_frame
);
  localparam int DIGIT_CYCLES = CLK_FREQ_HZ / (REFRESH_HZ * 8);
  localparam int CW = $clog2(DIGIT_CYCLES);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_LAST   = cnt_t'(DIGIT_CYCLES - 1);
  localparam cnt_t BLANK_LAST = cnt_t'(BLANK_CYCLES - 1);

  if (DIGIT_CYCLES <= BLANK_CYCLES) begin : g_bad_params
    $error("sevenseg_scanner: DIGIT_CYCLES must exceed BLANK_CYCLES");
  end

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [2:0]  dig_q, dig_d;
  logic [31:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [7:0]  act_en_q, act_en_d, pend_en_q, pend_en_d;
  logic [7:0]  act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic        pend_vld_q, pend_vld_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_n_q, dp_n_d;
  logic        frame_q, frame_d;
  logic        boundary;
  logic [3:0]  nibble;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b0000001;
      4'h1: decode = 7'b1001111;
      4'h2: decode = 7'b0010010;
      4'h3: decode = 7'b0000110;
      4'h4: decode = 7'b1001100;
      4'h5: decode = 7'b0100100;
      4'h6: decode = 7'b0100000;
      4'h7: decode = 7'b0001111;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0000100;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b1100000;
      4'hC: decode = 7'b0110001;
      4'hD: decode = 7'b1000010;
      4'hE: decode = 7'b0110000;
      default: decode = 7'b0111000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BLANK;
      cnt_q      <= '0;
      dig_q      <= '0;
      act_val_q  <= '0;
      act_en_q   <= '0;
      act_dp_q   <= '0;
      pend_val_q <= '0;
      pend_en_q  <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      an_q       <= 8'hFF;
      seg_q      <= 7'h7F;
      dp_n_q     <= 1'b1;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dig_q      <= dig_d;
      act_val_q  <= act_val_d;
      act_en_q   <= act_en_d;
      act_dp_q   <= act_dp_d;
      pend_val_q <= pend_val_d;
      pend_en_q  <= pend_en_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_n_q     <= dp_n_d;
      frame_q    <= frame_d;
    end
  end

  assign nibble   = act_val_q[{dig_q, 2'b00} +: 4];
  assign boundary = (state_q == DRIVE) && (cnt_q == CNT_LAST) && (dig_q == 3'd7);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + cnt_t'(1);
    dig_d   = dig_q;
    an_d    = 8'hFF;
    seg_d   = 7'h7F;
    dp_n_d  = 1'b1;
    frame_d = (state_q == BLANK) && (dig_q == 3'd0) && (cnt_q == '0);
    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) state_d = DRIVE;
      end
      default: begin
        an_d   = act_en_q[dig_q] ? ~(8'b1 << dig_q) : 8'hFF;
        seg_d  = decode(nibble);
        dp_n_d = ~(act_dp_q[dig_q] & act_en_q[dig_q]);
        if (cnt_q == CNT_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          dig_d   = dig_q + 3'd1;
        end
      end
    endcase
  end

  // A load landing on the wrap cycle goes straight to active; otherwise it waits in pending.
  always_comb begin
    act_val_d  = act_val_q;
    act_en_d   = act_en_q;
    act_dp_d   = act_dp_q;
    pend_val_d = pend_val_q;
    pend_en_d  = pend_en_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    if (boundary) begin
      if (i_load) begin
        act_val_d  = i_value;
        act_en_d   = i_en;
        act_dp_d   = i_dp;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        act_val_d  = pend_val_q;
        act_en_d   = pend_en_q;
        act_dp_d   = pend_dp_q;
        pend_vld_d = 1'b0;
      end
    end else if (i_load) begin
      pend_val_d = i_value;
      pend_en_d  = i_en;
      pend_dp_d  = i_dp;
      pend_vld_d = 1'b1;
    end
  end

  assign o_an    = an_q;
  assign o_seg   = seg_q;
  assign o_dp_n  = dp_n_q;
  assign o_frame = frame_q;
endmodule
